// File: rtl/apb_master_arbiter_pkg.sv
// Shared types for the APB master arbiter: transfer FSM states and index width helper.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // Width of an index into n items, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after last_i, wrapping.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int  pos;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    pos   = 0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last_i) + k) % N;
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IW'(pos);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master port between NUM_REQ requesters.
// Optional ACCESS-phase timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              PCLK,
  input  logic                              PRESET,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_strb,
  output logic [NUM_REQ-1:0]                req_ack,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              rsp_slverr,
  output logic [idx_w(NUM_REQ)-1:0]         grant_id,
  output logic                              PSEL,
  output logic                              PENABLE,
  output logic                              PWRITE,
  output logic [ADDR_WIDTH-1:0]             PADDR,
  output logic [DATA_WIDTH-1:0]             PWDATA,
  output logic [DATA_WIDTH/8-1:0]           PSTRB,
  input  logic [DATA_WIDTH-1:0]             PRDATA,
  input  logic                              PREADY,
  input  logic                              PSLVERR
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int SW = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];
  logic [SW-1:0]         strb_a  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_a[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign strb_a[gi]  = req_strb[gi*SW +: SW];
  end

  state_e                state_q, state_d;
  logic [IW-1:0]         last_q, last_d, grant_q, grant_d;
  logic [NUM_REQ-1:0]    goh_q, goh_d, ack_q, ack_d;
  logic                  psel_q, psel_d, pen_q, pen_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  logic                  slverr_q, slverr_d;
  logic                  timed_out;

  // Requests already acknowledged this cycle are masked to avoid a double grant.
  logic [NUM_REQ-1:0] cand, pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  assign cand = req_valid & ~ack_q;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req_i  (cand),
    .last_i (last_q),
    .gnt_o  (pick_oh),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = idx_w(TIMEOUT_CYCLES);
  logic [TW-1:0] timer_q, timer_d;
  assign timed_out = !PREADY && (timer_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    goh_d    = goh_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
`ifdef APB_ARB_TIMEOUT_EN
    timer_d  = timer_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d  = pick_idx;
          last_d   = pick_idx;
          goh_d    = pick_oh;
          paddr_d  = addr_a[pick_idx];
          pwrite_d = req_write[pick_idx];
          pwdata_d = wdata_a[pick_idx];
          pstrb_d  = strb_a[pick_idx];
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        pen_d   = 1'b1;
        state_d = ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        timer_d = '0;
`endif
      end
      ST_ACCESS: begin
        if (PREADY || timed_out) begin
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          ack_d   = goh_q;
          state_d = ST_IDLE;
          if (timed_out) begin
            rdata_d  = '0;
            slverr_d = 1'b1;
          end else begin
            rdata_d  = pwrite_q ? '0 : PRDATA;
            slverr_d = PSLVERR;
          end
        end
`ifdef APB_ARB_TIMEOUT_EN
        else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= ST_IDLE;
      last_q   <= IW'(NUM_REQ - 1);
      grant_q  <= '0;
      goh_q    <= '0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      timer_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      goh_q    <= goh_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
`ifdef APB_ARB_TIMEOUT_EN
      timer_q  <= timer_d;
`endif
    end
  end

  assign req_ack    = ack_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_slverr = slverr_q;
  assign grant_id   = grant_q;
  assign PSEL       = psel_q;
  assign PENABLE    = pen_q;
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign PSTRB      = pstrb_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed self-checking bench for apb_master_arbiter (4 requesters, 32-bit APB, timeout 8).
module tb_apb_master_arbiter;

  logic         PCLK = 1'b0;
  logic         PRESET;
  logic [3:0]   req_valid, req_write, req_ack;
  logic [127:0] req_addr, req_wdata;
  logic [15:0]  req_strb;
  logic [31:0]  rsp_rdata, PADDR, PWDATA, PRDATA;
  logic         rsp_slverr, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [1:0]   grant_id;
  logic [3:0]   PSTRB;

  int vectors = 0;
  int miscompares = 0;

  apb_master_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_ack(req_ack),
    .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .grant_id(grant_id),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    req_strb = '0; PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
    tick(); tick();
    chk("rst_psel", PSEL, 0);       chk("rst_penable", PENABLE, 0);
    chk("rst_ack", req_ack, 0);     chk("rst_grant", grant_id, 0);
    chk("rst_rdata", rsp_rdata, 0); chk("rst_paddr", PADDR, 0);
    PRESET = 1'b0;

    // Single read, zero wait (cycle 0 = request cycle)
    req_valid = 4'b0001; req_addr[31:0] = 32'h1000; PRDATA = 32'hA5A5_0001;
    tick();
    chk("rd_c1_psel", PSEL, 1); chk("rd_c1_pen", PENABLE, 0); chk("rd_c1_paddr", PADDR, 32'h1000);
    chk("rd_c1_pwrite", PWRITE, 0);
    tick();
    chk("rd_c2_psel", PSEL, 1); chk("rd_c2_pen", PENABLE, 1); chk("rd_c2_ack", req_ack, 0);
    tick();
    chk("rd_c3_ack", req_ack, 4'b0001); chk("rd_c3_rdata", rsp_rdata, 32'hA5A5_0001);
    chk("rd_c3_psel", PSEL, 0); chk("rd_c3_slverr", rsp_slverr, 0);
    req_valid = '0; PRDATA = 32'h0;
    tick();
    chk("rd_c4_ack", req_ack, 0); chk("rd_c4_hold", rsp_rdata, 32'hA5A5_0001);
    chk("rd_c4_paddr_hold", PADDR, 32'h1000);

    // Fairness from reset: order 0,1,2,3,0 with acks 3 cycles apart
    PRESET = 1'b1; tick(); PRESET = 1'b0;
    for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = 32'h40 + 32'h100 * i;
    PRDATA = 32'h5555_0000;
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk($sformatf("fair%0d_psel", n), PSEL, 1);
      chk($sformatf("fair%0d_paddr", n), PADDR, 32'h40 + 32'h100 * (n % 4));
      chk($sformatf("fair%0d_noack", n), req_ack, 0);
      tick();
      tick();
      chk($sformatf("fair%0d_ack", n), req_ack, 4'b0001 << (n % 4));
      chk($sformatf("fair%0d_gid", n), grant_id, n % 4);
    end
    req_valid = '0;
    tick();

    // Write with error, two wait states; req2 granted after last grant 0
    req_valid = 4'b0100; req_write = 4'b0100; req_addr[95:64] = 32'h2000;
    req_wdata[95:64] = 32'hDEAD_BEEF; req_strb[11:8] = 4'h3; PREADY = 1'b0;
    PSLVERR = 1'b1; PRDATA = 32'h1234_5678;
    tick();
    chk("wr_c1_gid", grant_id, 2); chk("wr_c1_pwrite", PWRITE, 1);
    chk("wr_c1_pwdata", PWDATA, 32'hDEAD_BEEF); chk("wr_c1_pstrb", PSTRB, 4'h3);
    tick();
    req_addr[95:64] = 32'h9999;
    tick();
    chk("wr_c3_noack", req_ack, 0);
    tick();
    chk("wr_c4_noack", req_ack, 0); chk("wr_c4_pen", PENABLE, 1); chk("wr_c4_paddr", PADDR, 32'h2000);
    PREADY = 1'b1;
    tick();
    chk("wr_c5_ack", req_ack, 4'b0100); chk("wr_c5_slverr", rsp_slverr, 1);
    chk("wr_c5_rdata", rsp_rdata, 0); chk("wr_c5_psel", PSEL, 0);
    chk("wr_c5_pwdata_hold", PWDATA, 32'hDEAD_BEEF);
    req_valid = '0; req_write = '0; PSLVERR = 1'b0;
    tick();

    // Re-request in ack cycle: req1 stays valid, req3 pending -> req3 next
    req_addr[63:32] = 32'h3100; req_addr[127:96] = 32'h3300; PRDATA = 32'h0000_0031;
    req_valid = 4'b0010;
    tick();
    chk("rr_c1_gid", grant_id, 1);
    req_valid = 4'b1010;
    tick(); tick();
    chk("rr_c3_ack", req_ack, 4'b0010); chk("rr_c3_rdata", rsp_rdata, 32'h31);
    PRDATA = 32'h0000_0033;
    tick();
    chk("rr_c4_gid", grant_id, 3); chk("rr_c4_paddr", PADDR, 32'h3300); chk("rr_c4_psel", PSEL, 1);
    tick(); tick();
    chk("rr_c6_ack", req_ack, 4'b1000); chk("rr_c6_rdata", rsp_rdata, 32'h33);
    req_valid = 4'b0010;
    tick();
    chk("rr_c7_gid", grant_id, 1);
    tick(); tick();
    chk("rr_c9_ack", req_ack, 4'b0010);
    req_valid = '0;
    tick();

    // Long wait in ACCESS: times out only when the timeout feature is built in
    req_valid = 4'b0001; PREADY = 1'b0; PRDATA = 32'h0000_FFFF; PSLVERR = 1'b0;
    tick(); tick();
    chk("to_c2_pen", PENABLE, 1);
    repeat (7) tick();
    chk("to_c9_noack", req_ack, 0);
    tick();
`ifdef APB_ARB_TIMEOUT_EN
    chk("to_c10_ack", req_ack, 4'b0001); chk("to_c10_slverr", rsp_slverr, 1);
    chk("to_c10_rdata", rsp_rdata, 0); chk("to_c10_psel", PSEL, 0);
`else
    chk("to_c10_noack", req_ack, 0); chk("to_c10_psel", PSEL, 1); chk("to_c10_pen", PENABLE, 1);
    PREADY = 1'b1;
    tick();
    chk("to_c11_ack", req_ack, 4'b0001); chk("to_c11_slverr", rsp_slverr, 0);
    chk("to_c11_rdata", rsp_rdata, 32'h0000_FFFF);
`endif
    req_valid = '0; PREADY = 1'b1;
    tick();

    // Reset mid-transfer: req2 in ACCESS, then req0 wins first after reset
    req_valid = 4'b0100; PREADY = 1'b0; PRDATA = 32'h0000_00C2;
    tick();
    chk("mr_c1_gid", grant_id, 2);
    tick();
    chk("mr_c2_pen", PENABLE, 1);
    PRESET = 1'b1;
    tick();
    chk("mr_c3_psel", PSEL, 0); chk("mr_c3_pen", PENABLE, 0); chk("mr_c3_ack", req_ack, 0);
    PRESET = 1'b0; req_valid = 4'b0101; PRDATA = 32'h0000_00C0;
    tick();
    chk("mr_c4_gid", grant_id, 0); chk("mr_c4_psel", PSEL, 1); chk("mr_c4_paddr", PADDR, 32'h40);
    PREADY = 1'b1;
    tick(); tick();
    chk("mr_c6_ack", req_ack, 4'b0001); chk("mr_c6_rdata", rsp_rdata, 32'hC0);
    req_valid = 4'b0100; PRDATA = 32'h0000_00C2;
    tick();
    chk("mr_c7_gid", grant_id, 2);
    tick(); tick();
    chk("mr_c9_ack", req_ack, 4'b0100); chk("mr_c9_rdata", rsp_rdata, 32'hC2);
    req_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares one APB master port between `NUM_REQ` internal requesters, such as bridge front-ends and DMA/config engines, on the PCLK side of the AHB-to-APB path. It arbitrates round-robin between pending requests and sequences the APB SETUP/ACCESS phases. It returns read data and the error status to the granted requester with a single-cycle acknowledge.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 32: APB address width.
- `DATA_WIDTH`, 32: APB data width, a multiple of 8.
- `TIMEOUT_CYCLES`, 256: ACCESS-phase wait limit, used only with the timeout macro.

Ports:
- `PCLK` in 1: the single clock.
- `PRESET` in 1: synchronous reset, active-high.
- `req_valid` in NUM_REQ: per-requester request; held until its `req_ack`.
- `req_write` in NUM_REQ: 1 = write.
- `req_addr` in NUM_REQ*ADDR_WIDTH: flattened; requester i occupies slice i.
- `req_wdata` in NUM_REQ*DATA_WIDTH: flattened write data.
- `req_strb` in NUM_REQ*DATA_WIDTH/8: flattened byte strobes.
- `req_ack` out NUM_REQ: one-cycle completion pulse, one-hot.
- `rsp_rdata` out DATA_WIDTH: read data, valid while `req_ack` is high.
- `rsp_slverr` out 1: error status, valid while `req_ack` is high.
- `grant_id` out $clog2(NUM_REQ): index of the current or last granted requester.
- `PSEL`, `PENABLE`, `PWRITE` out 1: APB control.
- `PADDR` out ADDR_WIDTH; `PWDATA` out DATA_WIDTH; `PSTRB` out DATA_WIDTH/8.
- `PRDATA` in DATA_WIDTH; `PREADY` in 1; `PSLVERR` in 1.

## Operation
- FSM states are IDLE, SETUP and ACCESS.
- **IDLE:** the candidate set is `req_valid & ~req_ack`.
  - If the set is non-empty, grant the first set bit searching upward from `last_grant+1`, wrapping modulo NUM_REQ.
  - Register the granted slice onto PADDR/PWRITE/PWDATA/PSTRB, set PSEL=1, update `grant_id` and `last_grant`, then go to SETUP.
- **SETUP:** set PENABLE=1 and go to ACCESS. Address, control and data are held.
- **ACCESS:**
  - PREADY=0: hold all APB outputs.
  - PREADY=1: PSEL=0, PENABLE=0; `req_ack[grant_id]`=1; `rsp_rdata`=PRDATA on reads and 0 on writes; `rsp_slverr`=PSLVERR; go to IDLE.
- PADDR, PWDATA, PSTRB and PWRITE keep their last values after completion. Only PSEL and PENABLE return to 0.
- Requester rule: deassert `req_valid`, or present a new request, on the clock edge at which `req_ack` is seen high. Masking with `req_ack` prevents a double grant in the ack cycle.
- Request fields are sampled only at grant. Changes after the grant have no effect on the transfer in flight.
- `rsp_rdata` and `rsp_slverr` hold until the next ack.
- Reset values of all outputs are 0: `req_ack`, `rsp_rdata`, `rsp_slverr`, `grant_id`, and all APB outputs. The FSM resets to IDLE and `last_grant` resets to NUM_REQ-1, so requester 0 wins first.
- Reset mid-transfer: PSEL and PENABLE drop at the reset edge, no ack is issued, and the requester re-requests after reset.

## Timing
- Zero-wait transfer: `req_valid` high in IDLE at cycle 0 → PSEL=1 at cycle 1 (SETUP) → PENABLE=1 at cycle 2 → PREADY sampled at cycle 2 → `req_ack` pulse with PSEL=0 at cycle 3.
- Back-to-back transfers: the next grant is decided in the ack cycle, so the next PSEL rises at cycle 4. Peak throughput is one transfer per 3 cycles.
- Each PREADY-low cycle in ACCESS adds one cycle of latency.
- Fairness: while a requester stays asserted, at most NUM_REQ-1 other transfers precede it.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments on each PREADY-low cycle.
  - If PREADY is still 0 when the count equals TIMEOUT_CYCLES-1, the transfer terminates as if PREADY=1, with `rsp_slverr`=1 and `rsp_rdata`=0.
  - PREADY=1 in the same cycle as the limit completes normally, using PSLVERR.
- `APB_ARB_TIMEOUT_EN` undefined: no counter exists, ACCESS waits indefinitely, and `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `apb_arb_pkg` holds the FSM state enum (IDLE/SETUP/ACCESS) and the `$clog2`-based index width helper.
- Sub-module `rr_arbiter`: combinational round-robin pick from a request vector and `last_grant`. It outputs a one-hot grant and an index, and is reusable elsewhere.
- The top level holds the FSM, the APB output registers, the response registers and the optional timeout counter.

## Test plan
- **Single read, zero wait:** req0 reads 0x1000 with PRDATA=0xA5A5_0001 → PSEL at cycle 1, PENABLE at cycle 2, `req_ack`=0001 with `rsp_rdata`=0xA5A5_0001 at cycle 3.
- **Fairness:** all four requesters held valid from reset → grant order 0,1,2,3,0; each `req_ack` exactly 3 cycles apart.
- **Write with error:** req2 writes 0xDEAD_BEEF, strb 0x3, with 2 wait states and PSLVERR=1 → PWDATA/PSTRB match, ack at cycle 5, `rsp_slverr`=1, `rsp_rdata`=0.
- **Re-request in ack cycle:** req1 keeps `req_valid` high after its ack while req3 is pending → req3 is granted next, and req1 is not granted twice in a row.
- **Timeout:** with `APB_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=8, PREADY held at 0 → ack 8 cycles after PENABLE rises, `rsp_slverr`=1.
- **Reset mid-transfer:** PRESET asserted during ACCESS → next cycle PSEL=PENABLE=0, no ack; after release, req0 wins first.
